// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the N-channel round-robin bus arbiter:
// FSM states, access-size encodings, byte-enable masks and the access legality check.
package bus_arbiter_rr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // funct3[1:0] selects the access size, funct3[2] selects zero-extension
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   function automatic logic access_illegal(input logic       wen,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
      logic bad;
      bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      if (wen && f3[2]) begin
         bad = 1'b1;
      end
      if ((f3[1:0] == SZ_H) && addr_lo[0]) begin
         bad = 1'b1;
      end
      if ((f3[1:0] == SZ_W) && (addr_lo != 2'b00)) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// System-bus side of the arbiter: the arbiter drives it through the master
// modport, memory or interconnect answers through the slave modport.
interface bus_arbiter_rr_if #(
   parameter int ADDR_W = 32
);
   logic              bus_en;
   logic              wr_en;
   logic [31:0]       wr_data;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        byte_en;
   logic              ack;
   logic [31:0]       rd_data;

   modport master (
      output bus_en, wr_en, wr_data, addr, byte_en,
      input  ack, rd_data
   );

   modport slave (
      input  bus_en, wr_en, wr_data, addr, byte_en,
      output ack, rd_data
   );
endinterface

// File: rtl/bus_arbiter_rr_lane_fmt.sv
// Combinational byte-lane formatter: replicates store data across lanes,
// builds byte enables and extracts/extends load data for the selected access.
module bus_arbiter_rr_lane_fmt
   import bus_arbiter_rr_pkg::*;
(
   input  logic [2:0]  f3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rd_data_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wr_data_o,
   output logic [31:0] rdata_o
);
   logic [7:0]  rd_lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sext;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = rd_data_i[8*gi +: 8];
      assign wr_data_o[8*gi +: 8] = (f3_i[1:0] == SZ_B) ? wdata_i[7:0] :
                                    (f3_i[1:0] == SZ_H) ? wdata_i[8*(gi%2) +: 8] :
                                                          wdata_i[8*gi +: 8];
   end

   assign byte_sel = rd_lane[addr_lo_i];
   assign half_sel = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];
   assign sext     = ~f3_i[2];

   always_comb begin
      byte_en_o = BE_W;
      rdata_o   = rd_data_i;
      case (f3_i[1:0])
         SZ_B: begin
            byte_en_o = BE_B << addr_lo_i;
            rdata_o   = {{24{sext & byte_sel[7]}}, byte_sel};
         end
         SZ_H: begin
            byte_en_o = BE_H << addr_lo_i;
            rdata_o   = {{16{sext & half_sel[15]}}, half_sel};
         end
         default: begin
            byte_en_o = BE_W;
            rdata_o   = rd_data_i;
         end
      endcase
   end
endmodule

// File: rtl/bus_arbiter_rr.sv
// N-channel requester arbiter onto a single system-bus master port with
// fixed or round-robin grant, ack timeout and access-error reporting.
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int RR_MODE = 1,
   parameter int TIMEOUT = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_CH-1:0]        i_req,
   input  logic [NUM_CH-1:0]        i_wen,
   input  logic [3*NUM_CH-1:0]      i_f3,
   input  logic [ADDR_W*NUM_CH-1:0] i_addr,
   input  logic [32*NUM_CH-1:0]     i_wdata,
   output logic [NUM_CH-1:0]        o_ready,
   output logic [NUM_CH-1:0]        o_err,
   output logic [31:0]              o_rdata,
   bus_arbiter_rr_if.master         bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

   logic [2:0]        ch_f3    [NUM_CH];
   logic [ADDR_W-1:0] ch_addr  [NUM_CH];
   logic [31:0]       ch_wdata [NUM_CH];

   state_e            state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              wen_q, wen_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [CH_W-1:0]   gnt_sel;
   logic              busy;
   logic              resp;
   logic [3:0]        fmt_byte_en;
   logic [31:0]       fmt_wr_data;
   logic [31:0]       fmt_rdata;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_f3[gi]    = i_f3[3*gi +: 3];
      assign ch_addr[gi]  = i_addr[ADDR_W*gi +: ADDR_W];
      assign ch_wdata[gi] = i_wdata[32*gi +: 32];
      assign o_ready[gi]  = resp && (grant_q == CH_W'(gi));
      assign o_err[gi]    = resp && err_q && (grant_q == CH_W'(gi));
   end

   // Search starts at the pointer in round-robin mode, at channel 0 otherwise
   always_comb begin : p_grant
      int  idx;
      logic found;
      gnt_sel = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (RR_MODE != 0) ? int'(ptr_q) + k : k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (!found && i_req[CH_W'(idx)]) begin
            found   = 1'b1;
            gnt_sel = CH_W'(idx);
         end
      end
   end

   bus_arbiter_rr_lane_fmt u_lane_fmt (
      .f3_i      (f3_q),
      .addr_lo_i (addr_q[1:0]),
      .wdata_i   (wdata_q),
      .rd_data_i (bus.rd_data),
      .byte_en_o (fmt_byte_en),
      .wr_data_o (fmt_wr_data),
      .rdata_o   (fmt_rdata)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      wen_d   = wen_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_req) begin
               grant_d = gnt_sel;
               wen_d   = i_wen[gnt_sel];
               f3_d    = ch_f3[gnt_sel];
               addr_d  = ch_addr[gnt_sel];
               wdata_d = ch_wdata[gnt_sel];
               cnt_d   = '0;
               rdata_d = '0;
               if (access_illegal(i_wen[gnt_sel], ch_f3[gnt_sel], ch_addr[gnt_sel][1:0])) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            // An ack in the expiry cycle still completes the access cleanly
            if (bus.ack) begin
               rdata_d = wen_q ? 32'h0 : fmt_rdata;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else if (TIMEOUT > 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            ptr_d   = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         wen_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         wen_q   <= wen_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign busy = (state_q == ST_BUSY);
   assign resp = (state_q == ST_RESP);

   assign bus.bus_en  = busy;
   assign bus.wr_en   = busy & wen_q;
   assign bus.addr    = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.wr_data = busy ? fmt_wr_data : 32'h0;
   assign bus.byte_en = busy ? fmt_byte_en : 4'h0;
   assign o_rdata     = resp ? rdata_q : 32'h0;
endmodule
